// File: rtl/hash_count_table.sv
// Hash-bucketed saturating counter table with a 2-cycle update pipeline and a flush walker.
// Optional statistics outputs are enabled by defining HASH_COUNT_STATS_EN.

module crc #(
  parameter logic [31:0] POLY      = 32'h04c11db7,
  parameter int          DATA_BITS = 32,
  parameter int          OUT_BITS  = 32
) (
  input  logic [DATA_BITS-1:0] data,
  output logic [OUT_BITS-1:0]  crc_out
);

  logic [31:0] acc;
  logic        fb;

  // MSB-first CRC, zero initial value, no reflection, no final xor.
  // NOTE: always_comb uses blocking '=' so each loop step sees the previous one;
  // clocked state elsewhere uses non-blocking '<='.
  always_comb begin
    acc = '0;
    fb  = 1'b0;
    for (int i = DATA_BITS - 1; i >= 0; i--) begin
      fb  = acc[31] ^ data[i];
      acc = {acc[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
    end
  end

  assign crc_out = acc[OUT_BITS-1:0];

endmodule

module hash_count_table #(
  parameter int NUM_WAYS      = 4,
  parameter int NUM_ADDR_BITS = 10,
  parameter int NUM_KEY_BITS  = 32,
  parameter int NUM_CNT_BITS  = 16,
  parameter int NUM_INC_BITS  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [NUM_KEY_BITS-1:0] upd_key,
  input  logic [NUM_INC_BITS-1:0] upd_inc,
  input  logic                    clear,
  output logic                    busy,
  output logic                    res_valid,
  output logic                    res_hit,
  output logic                    res_drop,
  output logic [NUM_CNT_BITS-1:0] res_count
`ifdef HASH_COUNT_STATS_EN
  ,
  output logic [31:0]             stat_hits,
  output logic [31:0]             stat_misses,
  output logic [31:0]             stat_drops
`endif
);

  localparam int DEPTH = 1 << NUM_ADDR_BITS;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  typedef struct packed {
    logic                    vld;
    logic [NUM_KEY_BITS-1:0] key;
    logic [NUM_CNT_BITS-1:0] cnt;
  } way_t;

  typedef way_t [NUM_WAYS-1:0] bucket_t;

  bucket_t mem [DEPTH];

  logic [0:0]               state;
  logic [NUM_ADDR_BITS-1:0] clr_addr;

  logic [NUM_ADDR_BITS-1:0] upd_addr;
  logic                     accept;

  logic                     s1_valid;
  logic [NUM_KEY_BITS-1:0]  s1_key;
  logic [NUM_INC_BITS-1:0]  s1_inc;
  logic [NUM_ADDR_BITS-1:0] s1_addr;
  bucket_t                  rd_word;

  logic                     s2_valid;
  logic [NUM_ADDR_BITS-1:0] s2_addr;
  bucket_t                  s2_word;

  logic                     s3_valid;
  logic [NUM_ADDR_BITS-1:0] s3_addr;
  bucket_t                  s3_word;

  bucket_t                  cur;
  bucket_t                  nxt;
  logic                     hit;
  logic                     alloc;
  logic                     drop;
  logic [NUM_CNT_BITS:0]    hit_sum;
  logic [NUM_CNT_BITS-1:0]  new_cnt;
  logic [NUM_CNT_BITS:0]    inc_ext;
  logic [NUM_CNT_BITS-1:0]  inc_cnt;

  logic                     mem_we;
  logic [NUM_ADDR_BITS-1:0] mem_waddr;
  bucket_t                  mem_wdata;

  crc #(
    .POLY      (32'h04c11db7),
    .DATA_BITS (NUM_KEY_BITS),
    .OUT_BITS  (NUM_ADDR_BITS)
  ) u_crc (
    .data    (upd_key),
    .crc_out (upd_addr)
  );

  assign busy      = (state == ST_CLEAR);
  assign upd_ready = !busy;
  assign accept    = upd_valid && upd_ready;

  assign inc_ext = (NUM_CNT_BITS + 1)'(s1_inc);
  assign inc_cnt = NUM_CNT_BITS'(s1_inc);

  // Flush walker: clear (re)starts at address 0; reset also starts a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
    end else if (clear) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
    end else if (state == ST_CLEAR) begin
      if (&clr_addr) state <= ST_IDLE;
      clr_addr <= clr_addr + 1'b1;
    end
  end

  // Pending writes from the two previous updates are not yet visible in rd_word,
  // so the newest matching one overrides the memory copy.
  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    cur = rd_word;
    if (s3_valid && s3_addr == s1_addr) cur = s3_word;
    if (s2_valid && s2_addr == s1_addr) cur = s2_word;
    nxt     = cur;
    hit     = 1'b0;
    alloc   = 1'b0;
    hit_sum = '0;
    new_cnt = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!hit && cur[w].vld && cur[w].key == s1_key) begin
        hit         = 1'b1;
        hit_sum     = {1'b0, cur[w].cnt} + inc_ext;
        new_cnt     = hit_sum[NUM_CNT_BITS] ? '1 : hit_sum[NUM_CNT_BITS-1:0];
        nxt[w].cnt  = new_cnt;
      end
    end
    if (!hit) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (!alloc && !cur[w].vld) begin
          alloc      = 1'b1;
          nxt[w].vld = 1'b1;
          nxt[w].key = s1_key;
          nxt[w].cnt = inc_cnt;
          new_cnt    = inc_cnt;
        end
      end
    end
    drop = !hit && !alloc;
  end

  // Update writebacks are dropped while flushing so in-flight data cannot survive it.
  always_comb begin
    mem_we    = busy || s2_valid;
    mem_waddr = busy ? clr_addr : s2_addr;
    mem_wdata = busy ? bucket_t'('0) : s2_word;
  end

  // NOTE: the table array is deliberately not reset; a flush after reset invalidates it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (accept) rd_word <= mem[upd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_key    <= '0;
      s1_inc    <= '0;
      s1_addr   <= '0;
      s2_valid  <= 1'b0;
      s2_addr   <= '0;
      s2_word   <= '0;
      s3_valid  <= 1'b0;
      s3_addr   <= '0;
      s3_word   <= '0;
      res_valid <= 1'b0;
      res_hit   <= 1'b0;
      res_drop  <= 1'b0;
      res_count <= '0;
    end else begin
      s1_valid  <= accept;
      if (accept) begin
        s1_key  <= upd_key;
        s1_inc  <= upd_inc;
        s1_addr <= upd_addr;
      end
      s2_valid  <= s1_valid;
      s2_addr   <= s1_addr;
      s2_word   <= nxt;
      s3_valid  <= s2_valid;
      s3_addr   <= s2_addr;
      s3_word   <= s2_word;
      res_valid <= s1_valid;
      res_hit   <= s1_valid && hit;
      res_drop  <= s1_valid && drop;
      res_count <= s1_valid ? new_cnt : '0;
    end
  end

`ifdef HASH_COUNT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_drops  <= '0;
    end else if (clear) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_drops  <= '0;
    end else if (res_valid) begin
      if (res_hit) begin
        if (stat_hits != '1) stat_hits <= stat_hits + 1'b1;
      end else if (res_drop) begin
        if (stat_drops != '1) stat_drops <= stat_drops + 1'b1;
      end else begin
        if (stat_misses != '1) stat_misses <= stat_misses + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hash_count_table.sv
// Directed testbench for hash_count_table (2 ways, 16 buckets, 8-bit counts).
// Stats outputs are checked when HASH_COUNT_STATS_EN is defined.

module tb_hash_count_table;

  localparam int NW = 2;
  localparam int AB = 4;
  localparam int KB = 32;
  localparam int CB = 8;
  localparam int IB = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          upd_valid = 1'b0;
  logic          upd_ready;
  logic [KB-1:0] upd_key = '0;
  logic [IB-1:0] upd_inc = '0;
  logic          clear = 1'b0;
  logic          busy;
  logic          res_valid;
  logic          res_hit;
  logic          res_drop;
  logic [CB-1:0] res_count;
`ifdef HASH_COUNT_STATS_EN
  logic [31:0]   stat_hits;
  logic [31:0]   stat_misses;
  logic [31:0]   stat_drops;
`endif

  hash_count_table #(
    .NUM_WAYS      (NW),
    .NUM_ADDR_BITS (AB),
    .NUM_KEY_BITS  (KB),
    .NUM_CNT_BITS  (CB),
    .NUM_INC_BITS  (IB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .upd_valid (upd_valid),
    .upd_ready (upd_ready),
    .upd_key   (upd_key),
    .upd_inc   (upd_inc),
    .clear     (clear),
    .busy      (busy),
    .res_valid (res_valid),
    .res_hit   (res_hit),
    .res_drop  (res_drop),
    .res_count (res_count)
`ifdef HASH_COUNT_STATS_EN
    ,
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses),
    .stat_drops  (stat_drops)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    bit       vld;
    int       ks;
    bit [7:0] inc;
    bit       hit;
    bit       drop;
    bit [7:0] cnt;
  } vec_t;

  vec_t        vq[$];
  logic [31:0] keys [5];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference CRC as polynomial long division of key * x^32.
  function automatic logic [31:0] crc_ref(input logic [31:0] k);
    logic [63:0] v;
    logic [63:0] p;
    v = {k, 32'h0};
    p = 64'h1_04c1_1db7;
    for (int b = 63; b >= 32; b--) if (v[b]) v = v ^ (p << (b - 32));
    return v[31:0];
  endfunction

  function automatic logic [3:0] bucket_of(input logic [31:0] k);
    logic [31:0] c;
    c = crc_ref(k);
    return c[3:0];
  endfunction

  function automatic vec_t mk(input bit vld, input int ks, input int inc,
                              input bit hit, input bit drop, input int cnt);
    vec_t v;
    v.vld  = vld;
    v.ks   = ks;
    v.inc  = 8'(inc);
    v.hit  = hit;
    v.drop = drop;
    v.cnt  = 8'(cnt);
    return v;
  endfunction

  // Apply vq one entry per cycle; each result is due two cycles after its request.
  task automatic run_vectors(input string tag);
    int n;
    n = vq.size();
    for (int i = 0; i < n + 2; i++) begin
      @(posedge clk); #1;
      if (i < n) begin
        upd_valid = vq[i].vld;
        upd_key   = keys[vq[i].ks];
        upd_inc   = vq[i].inc;
      end else begin
        upd_valid = 1'b0;
      end
      @(negedge clk);
      if (i >= 2) begin
        if (vq[i-2].vld)
          check($sformatf("%s[%0d]", tag, i - 2),
                {res_valid, res_hit, res_drop, res_count},
                {1'b1, vq[i-2].hit, vq[i-2].drop, vq[i-2].cnt});
        else
          check($sformatf("%s[%0d]_idle", tag, i - 2), res_valid, 1'b0);
      end
    end
    vq.delete();
  endtask

  initial begin
    int nb;
    int extra;
    logic [3:0] ba;
    logic [3:0] bd;
    logic [31:0] k;
    int found;

    // A, B, C share a bucket; D and E sit in two other distinct buckets.
    keys[0] = 32'hCAFE_0001;
    ba      = bucket_of(keys[0]);
    bd      = ba;
    found   = 1;
    k       = keys[0];
    for (int i = 0; i < 20000 && found < 5; i++) begin
      k = k + 32'd1;
      if ((found == 1 || found == 2) && bucket_of(k) == ba) begin
        keys[found] = k;
        found++;
      end else if (found == 3 && bucket_of(k) != ba) begin
        keys[3] = k;
        bd      = bucket_of(k);
        found++;
      end else if (found == 4 && bucket_of(k) != ba && bucket_of(k) != bd) begin
        keys[4] = k;
        found++;
      end
    end

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_res", {res_valid, res_hit, res_drop, res_count}, 64'h0);
    check("reset_busy_ready", {busy, upd_ready}, 2'b10);

    // Post-reset flush length.
    @(posedge clk); #1;
    rst_n = 1'b1;
    nb = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) nb++;
      else break;
    end
    check("reset_flush_cycles", nb, 16);
    check("ready_after_flush", upd_ready, 1'b1);

    // Back-to-back stream: forwarding, drop, saturation, zero-increment allocation.
    vq.push_back(mk(1, 0,   5, 0, 0,   5));
    vq.push_back(mk(1, 0,   7, 1, 0,  12));
    vq.push_back(mk(1, 1,   1, 0, 0,   1));
    vq.push_back(mk(1, 2,   2, 0, 1,   0));
    vq.push_back(mk(1, 0,   1, 1, 0,  13));
    vq.push_back(mk(1, 3,   0, 0, 0,   0));
    vq.push_back(mk(1, 0,   1, 1, 0,  14));
    vq.push_back(mk(1, 3,   3, 1, 0,   3));
    vq.push_back(mk(0, 0,   0, 0, 0,   0));
    vq.push_back(mk(1, 2,   4, 0, 1,   0));
    vq.push_back(mk(1, 1, 250, 1, 0, 251));
    vq.push_back(mk(1, 1,  10, 1, 0, 255));
    vq.push_back(mk(1, 4, 200, 0, 0, 200));
    vq.push_back(mk(1, 4, 100, 1, 0, 255));
    vq.push_back(mk(1, 4,   0, 1, 0, 255));
    vq.push_back(mk(1, 1,   1, 1, 0, 255));
    run_vectors("stream1");

    // Clear one cycle after an update; a second update lands in the clear cycle.
    @(posedge clk); #1;
    upd_valid = 1'b1; upd_key = keys[0]; upd_inc = 8'd2;
    @(posedge clk); #1;
    clear = 1'b1; upd_key = keys[3]; upd_inc = 8'd1;
    @(posedge clk); #1;
    clear = 1'b0; upd_key = keys[1]; upd_inc = 8'd9;
    nb = 0;
    extra = 0;
    for (int kc = 2; kc < 60; kc++) begin
      if (kc > 2) begin
        @(posedge clk); #1;
      end
      @(negedge clk);
      if (kc == 2)
        check("clr_inflight_a", {res_valid, res_hit, res_drop, res_count}, {1'b1, 1'b1, 1'b0, 8'd16});
      else if (kc == 3)
        check("clr_inflight_d", {res_valid, res_hit, res_drop, res_count}, {1'b1, 1'b1, 1'b0, 8'd4});
      else if (res_valid)
        extra++;
      if (busy) begin
        nb++;
        if (upd_ready) extra++;
      end else begin
        upd_valid = 1'b0;
        break;
      end
    end
    upd_valid = 1'b0;
    check("clr_busy_cycles", nb, 16);
    check("clr_busy_ignored", extra, 0);

    vq.push_back(mk(1, 0, 3, 0, 0, 3));
    vq.push_back(mk(1, 3, 1, 0, 0, 1));
    vq.push_back(mk(1, 1, 1, 0, 0, 1));
    run_vectors("after_clear");

    // Clear during CLEAR restarts the walk.
    @(posedge clk); #1;
    clear = 1'b1;
    nb = 0;
    for (int kc = 1; kc < 60; kc++) begin
      @(posedge clk); #1;
      clear = (kc == 6);
      @(negedge clk);
      if (busy) nb++;
      else break;
    end
    clear = 1'b0;
    check("clr_restart_cycles", nb, 22);

    vq.push_back(mk(1, 0, 1, 0, 0, 1));
    run_vectors("after_restart");

    // Reset with an update in flight: no result may appear.
    @(posedge clk); #1;
    upd_valid = 1'b1; upd_key = keys[0]; upd_inc = 8'd5;
    @(posedge clk); #1;
    upd_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_res", {res_valid, res_hit, res_drop, res_count}, 64'h0);
    check("midrst_busy", busy, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    nb = 0;
    extra = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (res_valid) extra++;
      if (busy) nb++;
      else break;
    end
    check("midrst_flush_cycles", nb, 16);
    check("midrst_no_result", extra, 0);

    vq.push_back(mk(1, 0, 1, 0, 0, 1));
    vq.push_back(mk(1, 1, 1, 0, 0, 1));
    vq.push_back(mk(1, 2, 1, 0, 1, 0));
    vq.push_back(mk(1, 0, 1, 1, 0, 2));
    run_vectors("stats_seq");

`ifdef HASH_COUNT_STATS_EN
    @(posedge clk); #1;
    check("stat_hits", stat_hits, 32'd1);
    check("stat_misses", stat_misses, 32'd2);
    check("stat_drops", stat_drops, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hash_count_table.md
HASH_COUNT_TABLE -- requirements
Module: hash_count_table

Interface
REQ-001 SHALL have parameter NUM_WAYS, default 4, entries per bucket (1..4).
REQ-002 SHALL have parameter NUM_ADDR_BITS, default 10, bucket address width.
REQ-003 SHALL have parameter NUM_KEY_BITS, default 32, key width.
REQ-004 SHALL have parameter NUM_CNT_BITS, default 16, stored count width.
REQ-005 SHALL have parameter NUM_INC_BITS, default 8, increment width (≤ NUM_CNT_BITS).
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port upd_valid, input, 1, update request this cycle.
REQ-009 SHALL have port upd_ready, output, 1, the request is accepted when upd_valid && upd_ready.
REQ-010 SHALL have port upd_key, input, NUM_KEY_BITS, key to count.
REQ-011 SHALL have port upd_inc, input, NUM_INC_BITS, amount to add.
REQ-012 SHALL have port clear, input, 1, pulse that starts a table flush.
REQ-013 SHALL have port busy, output, 1, flush in progress.
REQ-014 SHALL have port res_valid, output, 1, result strobe.
REQ-015 SHALL have port res_hit, output, 1, key was already present.
REQ-016 SHALL have port res_drop, output, 1, key absent and bucket full, so the update is discarded.
REQ-017 SHALL have port res_count, output, NUM_CNT_BITS, count after the update (0 on drop).

Function
REQ-018 Bucket index SHALL be the low NUM_ADDR_BITS of the codebase crc module output (POLY 32'h04c11db7) over upd_key.
REQ-019 Each bucket SHALL hold NUM_WAYS entries {valid, key, count} in one memory word, read and written whole.
REQ-020 An accepted update at cycle t SHALL produce exactly one res_valid pulse at cycle t+2; the pipeline SHALL be fixed and non-stalling.
REQ-021 Hit: matching valid way count SHALL become min(count+upd_inc, 2^NUM_CNT_BITS-1); res_hit=1.
REQ-022 Miss with a free way: the lowest-index invalid way SHALL be written {1, key, upd_inc}; res_hit=0, res_drop=0.
REQ-023 Miss with a full bucket: the memory SHALL be unchanged; res_drop=1, res_count=0.
REQ-024 At most one way per bucket SHALL ever hold a given key.
REQ-025 Back-to-back updates (any keys, any buckets, one per cycle) SHALL yield results identical to sequential in-order processing, with bucket data forwarded from both writeback stages.
REQ-026 upd_ready SHALL equal !busy; requests while busy SHALL be ignored and SHALL produce no result.
REQ-027 Flush FSM states SHALL be IDLE and CLEAR.
REQ-028 IDLE→CLEAR SHALL occur on clear; CLEAR SHALL write all-invalid to addresses 0..2^NUM_ADDR_BITS-1, one per cycle, then return to IDLE.
REQ-029 busy SHALL be 1 throughout CLEAR.
REQ-030 In-flight updates accepted before clear SHALL complete and report results.
REQ-031 Those in-flight writes SHALL NOT survive the flush.
REQ-032 clear asserted during CLEAR SHALL restart the address walk at 0.
REQ-033 A flush SHALL take exactly 2^NUM_ADDR_BITS cycles.
REQ-034 With NUM_INC_BITS < NUM_CNT_BITS, upd_inc SHALL be zero-extended; upd_inc=0 on a miss SHALL still allocate.

Reset
REQ-035 While rst_n=0: res_valid=0, res_hit=0, res_drop=0, res_count=0, pipeline valids cleared.
REQ-036 Memory contents SHALL NOT be reset.
REQ-037 On rst_n deassertion the FSM SHALL enter CLEAR at address 0; busy SHALL be 1 from reset, so upd_ready=0.
REQ-038 Reset mid-operation SHALL discard all in-flight updates with no res_valid pulse.

Configuration
REQ-039 Macro HASH_COUNT_STATS_EN, when defined, SHALL add outputs stat_hits, stat_misses and stat_drops, each 32 bits.
REQ-040 Each stat counter SHALL increment at res_valid by outcome and saturate at all-ones.
REQ-041 The stat counters SHALL be zeroed by reset and by clear.
REQ-042 Without HASH_COUNT_STATS_EN the ports and logic SHALL be absent, with function otherwise identical.

Verification (NUM_WAYS=2, NUM_ADDR_BITS=4, NUM_CNT_BITS=8, NUM_INC_BITS=8)
REQ-043 Release reset -> busy=1 for exactly 16 cycles, then upd_ready=1.
REQ-044 Update key A inc 5 at t, key A inc 7 at t+1 -> t+2: hit=0, count=5; t+3: hit=1, count=12.
REQ-045 Keys A, B, C in the same bucket on consecutive cycles -> A new, B new, C res_drop=1, count=0.
REQ-046 Key A inc 200, then A inc 100 -> second result count=255, hit=1.
REQ-047 Clear one cycle after update A -> A's result still reported, busy for 16 cycles; A afterwards -> hit=0.
REQ-048 With HASH_COUNT_STATS_EN: sequence of REQ-045 then A again -> stat_hits=1, stat_misses=2, stat_drops=1.
